// File: rtl/mem_access.sv
// mem_access: MEM stage; performs loads/stores to external SRAM or the memory-mapped UART, feeds MEM/WB.
// Latency: SRAM read RD_WAIT+1 stall cycles, SRAM write WR_PULSE+3, UART data 2, status/no access 0.
// Backpressure: mmo_stall freezes upstream while an access is in flight; it drops in DONE so upstream advances.
module mem_access #(
  parameter int          RD_WAIT        = 1,
  parameter int          WR_PULSE       = 1,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic        mmi_clk,
  input  logic        mmi_rst,
  input  logic [15:0] mmi_instr,
  input  logic [15:0] mmi_pc,
  input  logic [15:0] mmi_data,
  input  logic [3:0]  mmi_wreg_addr,
  input  logic [15:0] mmi_mem_addr,
  input  logic [15:0] mmi_write_to_mem_data,
  input  logic [1:0]  mmi_rwe,
  output logic [15:0] mmo_instr,
  output logic [15:0] mmo_pc,
  output logic [3:0]  mmo_wreg_addr,
  output logic [15:0] mmo_data,
  output logic        mmo_stall,
  output logic [15:0] ram_addr,
  inout  wire  [15:0] ram_data,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  // Counter only has to reach the longer of the two strobe windows; keep at least 2 bits.
  localparam int MAX_CYC = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int CNT_W   = ($clog2(MAX_CYC) < 2) ? 2 : $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_LOW, WR_HOLD, U_RD, U_WR, DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      rdata;

  logic        rd_req;
  logic        wr_req;
  logic        is_udata;
  logic        is_stat;
  logic [15:0] uart_status;

  logic        stall_c;
  logic        bus_en;
  logic        addr_en;

  assign rd_req      = (mmi_rwe == 2'b10);
  assign wr_req      = (mmi_rwe == 2'b01);
  assign is_udata    = (mmi_mem_addr == UART_DATA_ADDR);
  assign is_stat     = (mmi_mem_addr == UART_STAT_ADDR);
  assign uart_status = {14'b0, uart_data_ready, uart_tbre & uart_tsre};

  assign mmo_instr     = mmi_instr;
  assign mmo_pc        = mmi_pc;
  assign mmo_wreg_addr = mmi_wreg_addr;

  // Stall is gated by reset so a pending request cannot freeze the pipe while held in reset.
  assign mmo_stall = mmi_rst & stall_c;
  assign ram_addr  = addr_en ? mmi_mem_addr : 16'h0000;
  assign ram_data  = bus_en ? mmi_write_to_mem_data : 16'bz;

  // State register; async reset drops straight to IDLE so strobes release mid-access.
  always_ff @(posedge mmi_clk or negedge mmi_rst) begin
    if (!mmi_rst) state <= IDLE;
    else          state <= next_state;
  end

  // Cycle counter for the RD and WR_LOW windows; cleared on every state change.
  always_ff @(posedge mmi_clk or negedge mmi_rst) begin
    if (!mmi_rst)                               cnt <= '0;
    else if (next_state != state)               cnt <= '0;
    else if (state == RD || state == WR_LOW)    cnt <= cnt + 1'b1;
  end

  // Read data capture on the final sampling edge of an SRAM or UART read.
  always_ff @(posedge mmi_clk or negedge mmi_rst) begin
    if (!mmi_rst)                                   rdata <= 16'h0000;
    else if ((state == RD && cnt == RD_LAST) || state == U_RD) rdata <= ram_data;
  end

  // Next-state and strobe/output decode; everything idles high/Z unless a state claims it.
  always_comb begin
    next_state = state;
    stall_c    = 1'b0;
    ram_ce_n   = 1'b1;
    ram_oe_n   = 1'b1;
    ram_we_n   = 1'b1;
    uart_rdn   = 1'b1;
    uart_wrn   = 1'b1;
    bus_en     = 1'b0;
    addr_en    = 1'b0;
    mmo_data   = mmi_data;
    unique case (state)
      IDLE: begin
        if (rd_req) begin
          if (is_stat) begin
            mmo_data = uart_status;
          end else begin
            stall_c    = 1'b1;
            next_state = is_udata ? U_RD : RD;
          end
        end else if (wr_req && !is_stat) begin
          stall_c    = 1'b1;
          next_state = is_udata ? U_WR : WR_SETUP;
        end
      end
      RD: begin
        stall_c  = 1'b1;
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
        addr_en  = 1'b1;
        if (cnt == RD_LAST) next_state = DONE;
      end
      WR_SETUP: begin
        stall_c    = 1'b1;
        ram_ce_n   = 1'b0;
        addr_en    = 1'b1;
        bus_en     = 1'b1;
        next_state = WR_LOW;
      end
      WR_LOW: begin
        stall_c  = 1'b1;
        ram_ce_n = 1'b0;
        ram_we_n = 1'b0;
        addr_en  = 1'b1;
        bus_en   = 1'b1;
        if (cnt == WR_LAST) next_state = WR_HOLD;
      end
      WR_HOLD: begin
        stall_c    = 1'b1;
        ram_ce_n   = 1'b0;
        addr_en    = 1'b1;
        bus_en     = 1'b1;
        next_state = DONE;
      end
      U_RD: begin
        stall_c    = 1'b1;
        uart_rdn   = 1'b0;
        next_state = DONE;
      end
      U_WR: begin
        stall_c    = 1'b1;
        uart_wrn   = 1'b0;
        bus_en     = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        if (rd_req) mmo_data = rdata;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized + directed bench for mem_access against a per-access cycle model.
// Latency: n/a (bench).
// Backpressure: the driver holds each request stable until the model's cycle list is consumed.
module tb_mem_access;

  localparam int RD_WAIT  = 1;
  localparam int WR_PULSE = 1;

  logic        mmi_clk = 1'b0;
  logic        mmi_rst = 1'b1;
  logic [15:0] mmi_instr = '0, mmi_pc = '0, mmi_data = '0;
  logic [3:0]  mmi_wreg_addr = '0;
  logic [15:0] mmi_mem_addr = '0, mmi_write_to_mem_data = '0;
  logic [1:0]  mmi_rwe = 2'b00;
  logic [15:0] mmo_instr, mmo_pc, mmo_data;
  logic [3:0]  mmo_wreg_addr;
  logic        mmo_stall;
  logic [15:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
  logic        uart_data_ready = 1'b0, uart_tbre = 1'b0, uart_tsre = 1'b0;

  mem_access #(.RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
    .mmi_clk(mmi_clk), .mmi_rst(mmi_rst), .mmi_instr(mmi_instr), .mmi_pc(mmi_pc),
    .mmi_data(mmi_data), .mmi_wreg_addr(mmi_wreg_addr), .mmi_mem_addr(mmi_mem_addr),
    .mmi_write_to_mem_data(mmi_write_to_mem_data), .mmi_rwe(mmi_rwe),
    .mmo_instr(mmo_instr), .mmo_pc(mmo_pc), .mmo_wreg_addr(mmo_wreg_addr),
    .mmo_data(mmo_data), .mmo_stall(mmo_stall), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_data_ready(uart_data_ready),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  always #5 mmi_clk = ~mmi_clk;

  // Initial SRAM contents, shared by the stub and the reference memory.
  function automatic logic [15:0] init_word(input int i);
    if (i == 16'h0040)      return 16'hBEEF;
    else if (i == 16'h0050) return 16'h1111;
    else                    return 16'(i * 40503 + 12345);
  endfunction

  // SRAM / UART stub on the shared bus.
  logic [15:0] sram [0:255];
  logic [15:0] ref_mem [0:255];
  logic [15:0] uart_rx = 16'h0000;
  logic        preloaded = 1'b0;
  logic        stub_en;
  logic [15:0] stub_val;

  always_comb begin
    stub_en  = 1'b0;
    stub_val = 16'h0000;
    if (!ram_ce_n && !ram_oe_n) begin
      stub_en  = 1'b1;
      stub_val = sram[ram_addr[7:0]];
    end else if (!uart_rdn) begin
      stub_en  = 1'b1;
      stub_val = uart_rx;
    end
  end
  assign ram_data = stub_en ? stub_val : 16'bz;

  always @(negedge mmi_clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
      preloaded <= 1'b1;
    end else if (!ram_ce_n && !ram_we_n) begin
      sram[ram_addr[7:0]] <= ram_data;
    end
  end

  // One expected cycle of DUT behaviour.
  typedef struct {
    logic        stall, ce_n, oe_n, we_n, rdn, wrn;
    logic        bus_en;
    logic [15:0] bus_val;
    logic        addr_chk;
    logic [15:0] addr;
    logic        data_chk;
    logic [15:0] data;
    logic        first_cyc, final_cyc;
    logic        lit_d_en;
    logic [15:0] lit_d;
    int          lit_stall, lit_pulse;
  } exp_t;

  exp_t expq[$];

  function automatic exp_t cyc(input logic st, ce, oe, we, rdn, wrn);
    exp_t e;
    e.stall = st; e.ce_n = ce; e.oe_n = oe; e.we_n = we; e.rdn = rdn; e.wrn = wrn;
    e.bus_en = 1'b0; e.bus_val = 16'h0000; e.addr_chk = !ce; e.addr = 16'h0000;
    e.data_chk = 1'b0; e.data = 16'h0000; e.first_cyc = 1'b0; e.final_cyc = 1'b0;
    e.lit_d_en = 1'b0; e.lit_d = 16'h0000; e.lit_stall = -1; e.lit_pulse = -1;
    return e;
  endfunction

  // Behavioural model: expand the request on the inputs into its cycle list.
  task automatic push_model(input bit partial, input logic lit_d_en, input logic [15:0] lit_d,
                            input int lit_stall, input int lit_pulse);
    exp_t e;
    exp_t lst[$];
    logic [15:0] a  = mmi_mem_addr;
    logic [15:0] wd = mmi_write_to_mem_data;
    bit rd   = (mmi_rwe == 2'b10);
    bit wr   = (mmi_rwe == 2'b01);
    bit stat = (a == 16'hBF01);
    bit ud   = (a == 16'hBF00);
    if (!(rd || wr) || stat) begin
      e = cyc(0, 1, 1, 1, 1, 1);
      e.data_chk = 1'b1;
      e.data = (rd && stat) ? {14'd0, uart_data_ready, uart_tbre & uart_tsre} : mmi_data;
      lst.push_back(e);
    end else begin
      lst.push_back(cyc(1, 1, 1, 1, 1, 1));
      if (rd && ud) begin
        lst.push_back(cyc(1, 1, 1, 1, 0, 1));
      end else if (rd) begin
        for (int i = 0; i < RD_WAIT; i++) begin
          e = cyc(1, 0, 0, 1, 1, 1); e.addr = a; lst.push_back(e);
        end
      end else if (ud) begin
        e = cyc(1, 1, 1, 1, 1, 0); e.bus_en = 1'b1; e.bus_val = wd; lst.push_back(e);
      end else begin
        e = cyc(1, 0, 1, 1, 1, 1); e.addr = a; e.bus_en = 1'b1; e.bus_val = wd;
        lst.push_back(e);
        if (!partial) begin
          e.we_n = 1'b0;
          for (int i = 0; i < WR_PULSE; i++) lst.push_back(e);
          e.we_n = 1'b1;
          lst.push_back(e);
          ref_mem[a[7:0]] = wd;
        end
      end
      if (!partial) begin
        e = cyc(0, 1, 1, 1, 1, 1);
        e.data_chk = 1'b1;
        e.data = rd ? (ud ? uart_rx : ref_mem[a[7:0]]) : mmi_data;
        lst.push_back(e);
      end
    end
    lst[0].first_cyc = 1'b1;
    if (!partial) begin
      lst[lst.size()-1].final_cyc = 1'b1;
      lst[lst.size()-1].lit_d_en  = lit_d_en;
      lst[lst.size()-1].lit_d     = lit_d;
      lst[lst.size()-1].lit_stall = lit_stall;
      lst[lst.size()-1].lit_pulse = lit_pulse;
    end
    foreach (lst[i]) expq.push_back(lst[i]);
  endtask

  // Apply one request, hold it for as many cycles as the model says it takes.
  task automatic txn(input logic [1:0] rwe, input logic [15:0] addr, input logic [15:0] wd,
                     input logic [15:0] d, input bit partial, input logic lit_d_en,
                     input logic [15:0] lit_d, input int lit_stall, input int lit_pulse);
    int n;
    mmi_rwe = rwe; mmi_mem_addr = addr; mmi_write_to_mem_data = wd; mmi_data = d;
    mmi_instr = 16'($urandom); mmi_pc = 16'($urandom); mmi_wreg_addr = 4'($urandom);
    push_model(partial, lit_d_en, lit_d, lit_stall, lit_pulse);
    n = expq.size();
    repeat (n) @(posedge mmi_clk);
    #1;
  endtask

  int checks = 0;
  int errors = 0;
  int stall_obs = 0;
  int pulse_obs = 0;
  exp_t cur;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: reset-time checks on every reset assertion, model checks on every clocked cycle.
  initial begin
    forever begin
      @(negedge mmi_clk or negedge mmi_rst);
      if (!mmi_rst) begin
        #1;
        chk1("rst_stall", mmo_stall, 1'b0);
        chk1("rst_ce_n", ram_ce_n, 1'b1);
        chk1("rst_oe_n", ram_oe_n, 1'b1);
        chk1("rst_we_n", ram_we_n, 1'b1);
        chk1("rst_rdn", uart_rdn, 1'b1);
        chk1("rst_wrn", uart_wrn, 1'b1);
        chk1("rst_bus_drv", dut.bus_en, 1'b0);
        chk("rst_ram_addr", ram_addr, 16'h0000);
      end else if (expq.size() != 0) begin
        cur = expq.pop_front();
        if (cur.first_cyc) begin
          stall_obs = 0;
          pulse_obs = 0;
        end
        if (mmo_stall) stall_obs++;
        if (!ram_we_n || !uart_wrn) pulse_obs++;
        chk1("stall", mmo_stall, cur.stall);
        chk1("ce_n", ram_ce_n, cur.ce_n);
        chk1("oe_n", ram_oe_n, cur.oe_n);
        chk1("we_n", ram_we_n, cur.we_n);
        chk1("uart_rdn", uart_rdn, cur.rdn);
        chk1("uart_wrn", uart_wrn, cur.wrn);
        chk1("bus_drv", dut.bus_en, cur.bus_en);
        if (cur.bus_en) chk("bus_val", ram_data, cur.bus_val);
        if (cur.addr_chk) chk("ram_addr", ram_addr, cur.addr);
        if (cur.data_chk) chk("mmo_data", mmo_data, cur.data);
        chk("instr_pass", mmo_instr, mmi_instr);
        chk("pc_pass", mmo_pc, mmi_pc);
        chk("wreg_pass", {12'd0, mmo_wreg_addr}, {12'd0, mmi_wreg_addr});
        if (cur.final_cyc) begin
          if (cur.lit_d_en) chk("lit_data", mmo_data, cur.lit_d);
          if (cur.lit_stall >= 0) chk("lit_stall_cycles", 16'(stall_obs), 16'(cur.lit_stall));
          if (cur.lit_pulse >= 0) chk("lit_pulse_cycles", 16'(pulse_obs), 16'(cur.lit_pulse));
        end
      end
    end
  end

  // Driver: reset, directed cases with literal expectations, mid-write reset, then random traffic.
  initial begin
    logic [15:0] a;
    int r;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    #2;
    mmi_rwe = 2'b10; mmi_mem_addr = 16'h0040;
    mmi_rst = 1'b0;
    #10;
    mmi_rwe = 2'b00;
    mmi_rst = 1'b1;
    @(posedge mmi_clk);
    #1;

    // No access, both encodings.
    txn(2'b00, 16'h0040, 16'h0000, 16'h5A5A, 0, 1, 16'h5A5A, 0, 0);
    txn(2'b11, 16'h0040, 16'h0000, 16'h5A5A, 0, 1, 16'h5A5A, 0, 0);
    // SRAM read then write back-to-back, then readback.
    txn(2'b10, 16'h0040, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, RD_WAIT + 1, 0);
    txn(2'b01, 16'h0041, 16'h1234, 16'h0000, 0, 0, 16'h0000, WR_PULSE + 3, WR_PULSE);
    txn(2'b10, 16'h0041, 16'h0000, 16'h0000, 0, 1, 16'h1234, RD_WAIT + 1, 0);
    txn(2'b10, 16'h0040, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, RD_WAIT + 1, 0);
    txn(2'b01, 16'h0042, 16'hA55A, 16'h7777, 0, 1, 16'h7777, WR_PULSE + 3, WR_PULSE);
    // UART data write and read, status read and ignored status write.
    txn(2'b01, 16'hBF00, 16'h0041, 16'h0000, 0, 0, 16'h0000, 2, 1);
    uart_rx = 16'h00A5;
    txn(2'b10, 16'hBF00, 16'h0000, 16'h0000, 0, 1, 16'h00A5, 2, 0);
    uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
    txn(2'b10, 16'hBF01, 16'h0000, 16'h0000, 0, 1, 16'h0002, 0, 0);
    txn(2'b01, 16'hBF01, 16'hFFFF, 16'h3C3C, 0, 1, 16'h3C3C, 0, 0);

    // Reset asserted while we_n is low; the write must be abandoned.
    txn(2'b01, 16'h0050, 16'hCAFE, 16'h0000, 1, 0, 16'h0000, -1, -1);
    mmi_rst = 1'b0;
    #3;
    mmi_rwe = 2'b00;
    mmi_rst = 1'b1;
    txn(2'b00, 16'h0050, 16'h0000, 16'h2468, 0, 1, 16'h2468, 0, 0);
    txn(2'b10, 16'h0050, 16'h0000, 16'h0000, 0, 1, 16'h1111, RD_WAIT + 1, 0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0)      a = 16'hBF00;
      else if (r == 1) a = 16'hBF01;
      else             a = 16'($urandom_range(0, 255));
      uart_rx = 16'($urandom);
      uart_data_ready = 1'($urandom); uart_tbre = 1'($urandom); uart_tsre = 1'($urandom);
      txn(2'($urandom_range(0, 3)), a, 16'($urandom), 16'($urandom), 0, 0, 16'h0000, -1, -1);
    end

    repeat (2) @(posedge mmi_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
